// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter.
// A small FIFO accepts bytes from a valid/ready producer. A baud-paced FSM
// serialises each byte as a start bit, LSB-first data, an optional parity
// bit and one or two stop bits. Consecutive frames are sent back-to-back.

module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_clk,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_pin,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(DATA_BITS);

    // Out-of-range PARITY values fall back to "no parity".
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 1);

    // Stop-period counter value that marks the final stop period.
    localparam logic STOP_LAST = (STOP_BITS == 2);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;
    logic                 has_data;

    // Ready depends only on the registered count, so a full FIFO refuses
    // a write even on the edge where the FSM pops an entry.
    assign tx_ready   = (count < CW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign has_data   = (count != '0);
    assign fifo_count = count;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic                 pin_q,   pin_d;
    logic [BCW-1:0]       bit_q,   bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q,   par_d;
    logic                 stop_q,  stop_d;

    logic [DATA_BITS-1:0] head_byte;
    logic                 head_par;

    // Oldest FIFO entry and its parity bit, used whenever a frame is launched.
    always_comb begin
        head_byte = mem[rd_ptr];
        head_par  = PAR_ODD ? ~(^head_byte) : (^head_byte);
    end

    // FSM registers; the line idles high and returns high on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pin_q   <= 1'b1;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
        end
    end

    // Next-state logic; everything holds unless baud_clk marks a bit boundary.
    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        stop_d  = stop_q;
        pop     = 1'b0;

        if (baud_clk) begin
            case (state_q)
                IDLE: begin
                    if (has_data) begin
                        pop     = 1'b1;
                        shreg_d = head_byte;
                        par_d   = head_par;
                        pin_d   = 1'b0;
                        state_d = START;
                    end
                end

                START: begin
                    pin_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end

                DATA: begin
                    if (bit_q == BIT_LAST) begin
                        if (PAR_EN) begin
                            pin_d   = par_q;
                            state_d = PARITY_BIT;
                        end else begin
                            pin_d   = 1'b1;
                            stop_d  = 1'b0;
                            state_d = STOP;
                        end
                    end else begin
                        pin_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + BCW'(1);
                    end
                end

                PARITY_BIT: begin
                    pin_d   = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end

                STOP: begin
                    if (stop_q == STOP_LAST) begin
                        // Chain straight into the next start bit when more
                        // data is queued, so frames leave with no idle gap.
                        if (has_data) begin
                            pop     = 1'b1;
                            shreg_d = head_byte;
                            par_d   = head_par;
                            pin_d   = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    pin_d   = 1'b1;
                end
            endcase
        end
    end

    assign tx_pin  = pin_q;
    assign tx_busy = (state_q != IDLE) || has_data;

endmodule
